// File: rtl/shift_seq_ctrl_pkg.sv
// Shared definitions for the shift sequencer: state encodings and default sizes.
// Used by the RTL and by the testbench.
package shift_seq_ctrl_pkg;

  localparam int WIDTH_DEF = 6;
  localparam int CNT_W_DEF = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/shift_seq_ctrl_shift_reg_left.sv
// Left-shift datapath register with load priority over shift.
// Fill bit: q MSB (rotate) when SHIFT_ROTATE_EN is defined, else zero.
module shift_reg_left #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             ld,
  input  logic             sh_en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic fill;

`ifdef SHIFT_ROTATE_EN
  assign fill = q[WIDTH-1];
`else
  assign fill = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (clear) begin
      q <= '0;
    end else if (ld) begin
      q <= d;
    end else if (sh_en) begin
      q <= {q[WIDTH-2:0], fill};
    end
  end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Sequencer: load a word, shift it left a programmed number of steps, pulse done.
// Build option SHIFT_ROTATE_EN selects rotate instead of zero-fill in the datapath.
//
// state | meaning
// IDLE  | waiting for start; amount/data_in captured on accept
// LOAD  | ld strobe, datapath takes the held word
// SHIFT | sh_en asserted, cnt counts down to 1
// DONE  | one-cycle done pulse, then back to IDLE
module shift_seq_ctrl
  import shift_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             start,
  input  logic [CNT_W-1:0] amount,
  input  logic [WIDTH-1:0] data_in,
  output logic             busy,
  output logic             done,
  output logic             ld,
  output logic             sh_en,
  output logic [WIDTH-1:0] q
);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] hold;

  always_ff @(posedge clk) begin
    if (clear) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_LOAD;
      ST_LOAD:  state_nxt = (cnt == '0) ? ST_DONE : ST_SHIFT;
      ST_SHIFT: if (cnt == CNT_W'(1)) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    ld    = (state == ST_LOAD);
    sh_en = (state == ST_SHIFT);
    busy  = (state == ST_LOAD) || (state == ST_SHIFT);
    done  = (state == ST_DONE);
  end

  // Down-counter of remaining shift steps; guarded so it never wraps below zero.
  always_ff @(posedge clk) begin
    if (clear) begin
      cnt  <= '0;
      hold <= '0;
    end else if (state == ST_IDLE && start) begin
      cnt  <= amount;
      hold <= data_in;
    end else if (state == ST_SHIFT && cnt != '0) begin
      cnt  <= cnt - CNT_W'(1);
    end
  end

  shift_reg_left #(
    .WIDTH (WIDTH)
  ) u_shift_reg (
    .clk   (clk),
    .clear (clear),
    .ld    (ld),
    .sh_en (sh_en),
    .d     (hold),
    .q     (q)
  );

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Scoreboard bench for shift_seq_ctrl: a request-level model pushes expected
// transactions, a negedge monitor checks strobes and pops results on done.
module tb_shift_seq_ctrl;
  import shift_seq_ctrl_pkg::*;

  localparam int W = WIDTH_DEF;
  localparam int C = CNT_W_DEF;

  logic         clk = 1'b0;
  logic         clear;
  logic         start;
  logic [C-1:0] amount;
  logic [W-1:0] data_in;
  logic         busy, done, ld, sh_en;
  logic [W-1:0] q;

  shift_seq_ctrl #(.WIDTH(W), .CNT_W(C)) dut (
    .clk     (clk),
    .clear   (clear),
    .start   (start),
    .amount  (amount),
    .data_in (data_in),
    .busy    (busy),
    .done    (done),
    .ld      (ld),
    .sh_en   (sh_en),
    .q       (q)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           acc;
    int           amt;
    logic [W-1:0] res;
  } exp_t;

  exp_t sb[$];

  int   ecnt      = 0;
  int   idle_from = 0;
  int   clr_cnt   = 0;
  int   checks    = 0;
  int   errors    = 0;
  logic chk_en    = 1'b0;
  logic finish_req = 1'b0;
  logic mon_ack   = 1'b0;

  function automatic logic [W-1:0] ref_q(input logic [W-1:0] d, input int n);
    int v;
    v = int'(d);
`ifdef SHIFT_ROTATE_EN
    n = n % W;
    if (n == 0) return d;
    return W'((v << n) | (v >> (W - n)));
`else
    if (n >= W) return '0;
    return W'(v << n);
`endif
  endfunction

  // Request-level model: one request in flight, next accepted amount+3 edges later.
  initial forever begin
    @(posedge clk);
    ecnt = ecnt + 1;
    if (clear) begin
      clr_cnt   = clr_cnt + 1;
      idle_from = ecnt + 1;
    end else if (start && ecnt >= idle_from) begin
      sb.push_back('{acc: ecnt, amt: int'(amount), res: ref_q(data_in, int'(amount))});
      idle_from = ecnt + int'(amount) + 3;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks = checks + 1;
    if (act != exp) begin
      errors = errors + 1;
      $display("FAIL %s at edge %0d: got %0d expected %0d", name, ecnt, act, exp);
    end
  endtask

  int   clr_seen = 0;
  logic [W-1:0] last_q = '0;

  initial forever begin
    exp_t t;
    logic e_ld, e_sh, e_done;
    @(negedge clk);
    if (chk_en) begin
      if (clr_cnt != clr_seen) begin
        clr_seen = clr_cnt;
        last_q   = '0;
        sb.delete();
      end
      e_ld = 1'b0; e_sh = 1'b0; e_done = 1'b0;
      t = '{acc: 0, amt: 0, res: '0};
      if (sb.size() > 0) begin
        t      = sb[0];
        e_ld   = (ecnt == t.acc);
        e_sh   = (ecnt > t.acc) && (ecnt <= t.acc + t.amt);
        e_done = (ecnt == t.acc + t.amt + 1);
      end
      chk("ld", int'(ld), int'(e_ld));
      chk("sh_en", int'(sh_en), int'(e_sh));
      chk("busy", int'(busy), int'(e_ld || e_sh));
      chk("done", int'(done), int'(e_done));
      if (!(e_ld || e_sh)) chk("q", int'(q), int'(e_done ? t.res : last_q));
      if (e_done) begin
        last_q = t.res;
        void'(sb.pop_front());
      end
      if (finish_req && !mon_ack) begin
        chk("sb_empty", sb.size(), 0);
        mon_ack = 1'b1;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic req(input logic [W-1:0] d, input logic [C-1:0] a);
    start = 1'b1; data_in = d; amount = a;
    cyc(1);
    start = 1'b0; data_in = W'($urandom); amount = C'($urandom);
    cyc(int'(a) + 3);
  endtask

  initial begin
    clear = 1'b1; start = 1'b0; amount = '0; data_in = '0;
    cyc(2);
    chk_en = 1'b1;
    cyc(1);
    clear = 1'b0;
    cyc(1);

    req(6'b000001, 3'd5);
    req(6'b101101, 3'd0);
    req(6'b000011, 3'd7);

    // second request during SHIFT must be ignored
    start = 1'b1; data_in = 6'b010011; amount = 3'd3;
    cyc(1);
    start = 1'b0;
    cyc(2);
    start = 1'b1; data_in = 6'b111111; amount = 3'd1;
    cyc(1);
    start = 1'b0;
    cyc(6);

    // clear in the second SHIFT cycle, then a fresh request
    start = 1'b1; data_in = 6'b110101; amount = 3'd5;
    cyc(1);
    start = 1'b0;
    cyc(2);
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    cyc(2);
    req(6'b100111, 3'd2);

    // start held high, amount=1: one accept every 4 cycles
    start = 1'b1; amount = 3'd1;
    repeat (16) begin
      data_in = W'($urandom);
      cyc(1);
    end
    start = 1'b0;
    cyc(4);

    repeat (800) begin
      start   = ($urandom_range(0, 2) != 0);
      clear   = ($urandom_range(0, 39) == 0);
      amount  = C'($urandom);
      data_in = W'($urandom);
      cyc(1);
    end
    start = 1'b0; clear = 1'b0;
    cyc(12);

    finish_req = 1'b1;
    for (int i = 0; i < 10 && !mon_ack; i++) cyc(1);
    if (!mon_ack) begin
      $display("FAIL monitor_ack: got 0 expected 1");
      $fatal(1, "monitor did not acknowledge");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
